div_unit: RTL and testbench

- Multicycle signed 32-bit divider serving the control unit's start/done handshake. It is the counterpart to the multiplier: the control unit pulses a start line, then waits for a one-cycle done pulse.
- Performs restoring division on operand magnitudes, then applies a sign fix-up.
- Lo carries the quotient and Hi the remainder, to be loaded into the HI/LO registers through their input muxes.
- Flags divide-by-zero so the control unit can take its exception path.

---
 rtl/div_unit.sv | 176 +++++++++++++++++
 tb/tb_div_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//
// Multicycle signed divider for the control unit's start/done handshake.
// Restoring division runs on operand magnitudes, one quotient bit per cycle,
// followed by a sign fix-up. Lo carries the quotient and Hi the remainder.
//
// Ports
//   Clk         system clock, rising edge
//   Reset       synchronous reset, active low (0 = reset)
//   DivControl  start request, sampled only while idle
//   DivA        dividend (two's complement), sampled when a start is accepted
//   DivB        divisor  (two's complement), sampled when a start is accepted
//   Hi          remainder (sign follows the dividend)
//   Lo          quotient  (truncated toward zero)
//   out         one-cycle done pulse
//   DivZero     divide-by-zero flag, valid while out is high
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for DivControl; latches magnitudes and signs on start
// S_CALC | one restoring-division iteration per cycle, WIDTH iterations
// S_FIX  | applies signs and loads Hi/Lo
// S_DONE | final cycle of the operation; done pulse is issued on leaving
// ---------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             DivControl,
    input  logic [WIDTH-1:0] DivA,
    input  logic [WIDTH-1:0] DivB,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             out,
    output logic             DivZero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   rem_q,   rem_d;
    logic [WIDTH-1:0]   quo_q,   quo_d;
    logic [WIDTH-1:0]   absb_q,  absb_d;
    logic [WIDTH-1:0]   hi_q,    hi_d;
    logic [WIDTH-1:0]   lo_q,    lo_d;
    logic               signa_q, signa_d;
    logic               signb_q, signb_d;
    logic               dz_q,    dz_d;
    logic               out_q,   out_d;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   rem_sh;
    logic [WIDTH-1:0]   quo_sh;
    logic [WIDTH:0]     trial;

    // Magnitudes are taken as unsigned, so the most negative value maps onto
    // itself and is divided as 2^(WIDTH-1).
    assign abs_a = DivA[WIDTH-1] ? (~DivA + 1'b1) : DivA;
    assign abs_b = DivB[WIDTH-1] ? (~DivB + 1'b1) : DivB;

    // The quotient register starts out holding the dividend magnitude; its MSB
    // feeds the remainder as {rem, q} shifts left, and the freed LSB receives
    // the new quotient bit.
    assign rem_sh = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    assign quo_sh = {quo_q[WIDTH-2:0], 1'b0};
    // One extra bit so the borrow shows whether the trial went negative.
    assign trial  = {1'b0, rem_sh} - {1'b0, absb_q};

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            absb_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            signa_q <= 1'b0;
            signb_q <= 1'b0;
            dz_q    <= 1'b0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            absb_q  <= absb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            signa_q <= signa_d;
            signb_q <= signb_d;
            dz_q    <= dz_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        absb_d  = absb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        signa_d = signa_q;
        signb_d = signb_q;
        dz_d    = dz_q;
        // Registered so the pulse lands one cycle after the DONE state.
        out_d   = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (DivControl) begin
                    quo_d   = abs_a;
                    absb_d  = abs_b;
                    signa_d = DivA[WIDTH-1];
                    signb_d = DivB[WIDTH-1];
                    rem_d   = '0;
                    cnt_d   = '0;
                    if (DivB == '0) begin
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        dz_d    = 1'b0;
                        state_d = S_CALC;
                    end
                end
            end

            S_CALC: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = quo_sh | {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    rem_d = rem_sh;
                    quo_d = quo_sh;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                lo_d    = (signa_q ^ signb_q) ? (~quo_q + 1'b1) : quo_q;
                hi_d    = signa_q ? (~rem_q + 1'b1) : rem_q;
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Hi      = hi_q;
    assign Lo      = lo_q;
    assign out     = out_q;
    assign DivZero = dz_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        Clk;
    logic        Reset;
    logic        DivControl;
    logic [31:0] DivA;
    logic [31:0] DivB;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        out;
    logic        DivZero;

    int n_cmp;
    int n_err;

    // Reference state: what Hi/Lo/DivZero should hold after each operation.
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;

    div_unit #(.WIDTH(32)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .DivControl (DivControl),
        .DivA       (DivA),
        .DivB       (DivB),
        .Hi         (Hi),
        .Lo         (Lo),
        .out        (out),
        .DivZero    (DivZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Signed division with plain 64-bit arithmetic: truncation toward zero,
    // remainder follows the dividend; MIN/-1 wraps to MIN naturally.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        lq = sa / sb;
        lr = sa % sb;
        q  = lq[31:0];
        r  = lr[31:0];
    endtask

    // mode 0: plain, 1: restart attempt + operand change at cycle evt,
    // 2: reset at cycle evt, 3: DivControl held high (two back-to-back ops)
    task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                       input int mode, input int evt, input int ncyc);
        int          pulses[$];
        logic [31:0] cap_hi, cap_lo, mq, mr;
        logic        cap_dz;
        int          exp_n, exp_first;
        cap_hi = '0;
        cap_lo = '0;
        cap_dz = 1'b0;

        @(negedge Clk);
        DivA       = a;
        DivB       = b;
        DivControl = 1'b1;
        Reset      = 1'b1;
        @(posedge Clk);                       // edge N: start accepted
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge Clk);
            Reset      = 1'b1;
            DivControl = (mode == 3) && (k < ncyc);
            if (mode != 3) begin
                DivA = $urandom;
                DivB = $urandom;
            end
            if (mode == 1 && k == evt) DivControl = 1'b1;
            if (mode == 2 && k == evt) Reset = 1'b0;
            @(posedge Clk);
            #1;
            if (out === 1'b1) begin
                if (pulses.size() == 0) begin
                    cap_hi = Hi;
                    cap_lo = Lo;
                    cap_dz = DivZero;
                end
                pulses.push_back(k);
            end
        end
        @(negedge Clk);
        Reset      = 1'b1;
        DivControl = 1'b0;

        if (mode == 2) begin
            exp_hi    = '0;
            exp_lo    = '0;
            exp_dz    = 1'b0;
            exp_n     = 0;
            exp_first = 0;
        end else begin
            if (b == 32'd0) begin
                exp_dz = 1'b1;
            end else begin
                model(a, b, mq, mr);
                exp_lo = mq;
                exp_hi = mr;
                exp_dz = 1'b0;
            end
            exp_first = (b == 32'd0) ? 1 : 34;
            exp_n     = (mode == 3) ? 2 : 1;
        end

        check({name, ".pulses"}, 32'(pulses.size()), 32'(exp_n));
        if (pulses.size() > 0 && exp_n > 0) begin
            check({name, ".done_edge"}, 32'(pulses[0]), 32'(exp_first));
            check({name, ".Lo"},      cap_lo, exp_lo);
            check({name, ".Hi"},      cap_hi, exp_hi);
            check({name, ".DivZero"}, {31'd0, cap_dz}, {31'd0, exp_dz});
        end
        if (pulses.size() > 1 && exp_n > 1)
            check({name, ".done2_edge"}, 32'(pulses[1]), 32'd69);
        if (mode == 2) begin
            check({name, ".Hi_rst"}, Hi, 32'd0);
            check({name, ".Lo_rst"}, Lo, 32'd0);
            check({name, ".DivZero_rst"}, {31'd0, DivZero}, 32'd0);
        end
    endtask

    initial begin
        int          seen;
        logic [31:0] ra, rb;
        n_cmp      = 0;
        n_err      = 0;
        exp_hi     = '0;
        exp_lo     = '0;
        exp_dz     = 1'b0;
        Reset      = 1'b0;
        DivControl = 1'b0;
        DivA       = '0;
        DivB       = '0;

        repeat (2) @(posedge Clk);
        #1;
        check("reset.Hi",      Hi, 32'd0);
        check("reset.Lo",      Lo, 32'd0);
        check("reset.out",     {31'd0, out}, 32'd0);
        check("reset.DivZero", {31'd0, DivZero}, 32'd0);

        run("p7d2",      32'd7,          32'd2,          0, 0, 40);
        run("m7d2",      32'hFFFF_FFF9,  32'd2,          0, 0, 40);
        run("p7dm2",     32'd7,          32'hFFFF_FFFE,  0, 0, 40);
        run("minDm1",    32'h8000_0000,  32'hFFFF_FFFF,  0, 0, 40);
        run("p5d9",      32'd5,          32'd9,          0, 0, 40);
        run("p7d2b",     32'd7,          32'd2,          0, 0, 40);
        run("divzero",   32'd123,        32'd0,          0, 0, 40);
        run("disturb",   32'd100,        32'd7,          1, 10, 40);
        run("rst_mid",   32'd100,        32'd7,          2, 20, 40);
        run("p9d3",      32'd9,          32'd3,          0, 0, 40);
        run("zero_dvd",  32'd0,          32'd5,          0, 0, 40);
        run("minDmin",   32'h8000_0000,  32'h8000_0000,  0, 0, 40);
        run("hold",      32'd7,          32'd2,          3, 0, 70);

        // Start and reset in the same cycle: reset wins, nothing runs.
        @(negedge Clk);
        Reset      = 1'b0;
        DivControl = 1'b1;
        DivA       = 32'd50;
        DivB       = 32'd5;
        @(posedge Clk);
        @(negedge Clk);
        Reset      = 1'b1;
        DivControl = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge Clk);
            #1;
            if (out === 1'b1) seen++;
        end
        exp_hi = '0;
        exp_lo = '0;
        exp_dz = 1'b0;
        check("rst_start.pulses", 32'(seen), 32'd0);
        check("rst_start.Lo", Lo, 32'd0);

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 2) == 0) ra = 32'($urandom_range(0, 1000)) * ($urandom_range(0, 1) == 1 ? -32'sd1 : 32'sd1);
            rb = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 40)) : $urandom;
            if ($urandom_range(0, 1) == 1) rb = ~rb + 32'd1;
            run($sformatf("rand%0d", i), ra, rb, 0, 0, 40);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
